seq_pattern_gen: RTL and testbench

Serial bit-pattern transmitter: accepts a programmed pattern (up to MAX_LEN bits) over a valid/ready start handshake and shifts it out MSB-first, one bit per clock. It optionally repeats it with idle gaps. It is the driving end of the single-bit `x` stream consumed by the team's sequence-detector FSMs. It serves both as a stimulus source in loopback benches and as an on-chip preamble/sync-word emitter.

---
 rtl/seq_gen_pkg.sv | 15 +
 rtl/pattern_mux_shifter.sv | 57 +++++
 rtl/seq_pattern_gen.sv | 133 +++++++++++++
 tb/tb_seq_pattern_gen.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// Shared types and default sizing for the serial pattern generator.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_MAX_LEN = 16;
  localparam int DEF_RPT_W   = 4;
  localparam int DEF_GAP_W   = 4;

endpackage

// File: rtl/pattern_mux_shifter.sv
// Holds the latched pattern and bit index; sel_bit is the bit that will be on
// the wire next cycle, so the top can register x without extra latency.
module pattern_mux_shifter
  import seq_gen_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               advance,
  input  logic               reload,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len_m1,
  output logic               sel_bit,
  output logic               last_bit
);

  logic [MAX_LEN-1:0] pattern_q;
  logic [MAX_LEN-1:0] pattern_nxt;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   len_nxt;
  logic [LEN_W-1:0]   bit_cnt;
  logic [LEN_W-1:0]   cnt_nxt;

  always_comb begin
    pattern_nxt = pattern_q;
    len_nxt     = len_q;
    cnt_nxt     = bit_cnt;
    if (load) begin
      pattern_nxt = pattern;
      len_nxt     = len_m1;
      cnt_nxt     = len_m1;
    end else if (reload) begin
      cnt_nxt = len_q;
    end else if (advance && (bit_cnt != '0)) begin
      cnt_nxt = bit_cnt - 1'b1;
    end
  end

  assign sel_bit  = pattern_nxt[cnt_nxt];
  assign last_bit = (bit_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q <= '0;
      len_q     <= '0;
      bit_cnt   <= '0;
    end else begin
      pattern_q <= pattern_nxt;
      len_q     <= len_nxt;
      bit_cnt   <= cnt_nxt;
    end
  end

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial MSB-first pattern transmitter with repeat count and idle gaps,
// started by a valid/ready handshake. All outputs are registered.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN),
  parameter int RPT_W   = DEF_RPT_W,
  parameter int GAP_W   = DEF_GAP_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len_m1,
  input  logic [RPT_W-1:0]   repeat_m1,
  input  logic [GAP_W-1:0]   gap,
  input  logic               abort,
  output logic               x,
  output logic               x_valid,
  output logic               busy,
  output logic               done
);

  state_t           state;
  logic [RPT_W-1:0] rpt_cnt;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;
  logic             accept;
  logic             advance;
  logic             reload;
  logic             sel_bit;
  logic             last_bit;

  // start_ready is a registered decode of IDLE/DONE, so it is safe to gate on
  assign accept  = start_valid && start_ready && !abort;
  assign advance = (state == SHIFT) && !abort && !last_bit;
  assign reload  = (state == SHIFT) && !abort && last_bit && (rpt_cnt != '0);

  pattern_mux_shifter #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .advance  (advance),
    .reload   (reload),
    .pattern  (pattern),
    .len_m1   (len_m1),
    .sel_bit  (sel_bit),
    .last_bit (last_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rpt_cnt     <= '0;
      gap_q       <= '0;
      gap_cnt     <= '0;
      x           <= 1'b0;
      x_valid     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      start_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state       <= IDLE;
        x           <= 1'b0;
        x_valid     <= 1'b0;
        busy        <= 1'b0;
        start_ready <= 1'b1;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (accept) begin
              state       <= SHIFT;
              rpt_cnt     <= repeat_m1;
              gap_q       <= gap;
              x           <= sel_bit;
              x_valid     <= 1'b1;
              busy        <= 1'b1;
              start_ready <= 1'b0;
            end else begin
              state       <= IDLE;
              x           <= 1'b0;
              x_valid     <= 1'b0;
              busy        <= 1'b0;
              start_ready <= 1'b1;
            end
          end
          SHIFT: begin
            if (!last_bit) begin
              x <= sel_bit;
            end else if (rpt_cnt != '0) begin
              rpt_cnt <= rpt_cnt - 1'b1;
              if (gap_q == '0) begin
                x <= sel_bit;
              end else begin
                gap_cnt <= gap_q - 1'b1;
                state   <= GAP;
                x       <= 1'b0;
                x_valid <= 1'b0;
              end
            end else begin
              state       <= DONE;
              x           <= 1'b0;
              x_valid     <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
              start_ready <= 1'b1;
            end
          end
          GAP: begin
            if (gap_cnt != '0) begin
              gap_cnt <= gap_cnt - 1'b1;
            end else begin
              state   <= SHIFT;
              x       <= sel_bit;
              x_valid <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: each accepted job pushes its expected
// per-cycle output trace; a negedge monitor pops and compares it.
module tb_seq_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_valid = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] pattern = '0;
  logic [3:0]  len_m1 = '0;
  logic [3:0]  repeat_m1 = '0;
  logic [3:0]  gap = '0;
  logic        start_ready;
  logic        x;
  logic        x_valid;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic v;
    logic x;
    logic b;
    logic d;
    logic r;
  } rec_t;

  rec_t        sb[$];
  rec_t        exp_rec;
  int          assert_cnt = 0;
  int          fail_cnt = 0;
  bit          mon_en = 1'b0;
  logic [2:0]  det;
  logic        z;

  seq_pattern_gen #(
    .MAX_LEN (16),
    .LEN_W   (4),
    .RPT_W   (4),
    .GAP_W   (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .pattern     (pattern),
    .len_m1      (len_m1),
    .repeat_m1   (repeat_m1),
    .gap         (gap),
    .abort       (abort),
    .x           (x),
    .x_valid     (x_valid),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // 1010 non-overlapping Moore detector fed by the generator's stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det <= 3'd0;
    end else if (!x_valid) begin
      det <= 3'd0;
    end else begin
      case (det)
        3'd0:    det <= x ? 3'd1 : 3'd0;
        3'd1:    det <= x ? 3'd1 : 3'd2;
        3'd2:    det <= x ? 3'd3 : 3'd0;
        3'd3:    det <= x ? 3'd1 : 3'd4;
        default: det <= x ? 3'd1 : 3'd0;
      endcase
    end
  end
  assign z = (det == 3'd4);

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assert_cnt++;
    if (actual !== expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0) exp_rec = sb.pop_front();
      else exp_rec = '{v: 1'b0, x: 1'b0, b: 1'b0, d: 1'b0, r: 1'b1};
      checkOutput("x_valid", x_valid, exp_rec.v);
      checkOutput("x", x, exp_rec.x);
      checkOutput("busy", busy, exp_rec.b);
      checkOutput("done", done, exp_rec.d);
      checkOutput("start_ready", start_ready, exp_rec.r);
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the handshake edge
  task automatic applyStimulus(input logic [15:0] pat, input logic [3:0] lm1,
                               input logic [3:0] rpt, input logic [3:0] gp);
    int waited = 0;
    bit acc = 1'b0;
    start_valid = 1'b1;
    pattern = pat;
    len_m1 = lm1;
    repeat_m1 = rpt;
    gap = gp;
    while (!acc && waited < 300) begin
      acc = start_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    start_valid = 1'b0;
    pattern = ~pat;
    len_m1 = lm1 ^ 4'h5;
    repeat_m1 = rpt ^ 4'h3;
    gap = gp ^ 4'h6;
    checkOutput("handshake", acc, 1);
    if (acc) begin
      for (int r = 0; r <= int'(rpt); r++) begin
        for (int i = int'(lm1); i >= 0; i--)
          sb.push_back('{v: 1'b1, x: pat[i], b: 1'b1, d: 1'b0, r: 1'b0});
        if (r < int'(rpt))
          for (int g = 0; g < int'(gp); g++)
            sb.push_back('{v: 1'b0, x: 1'b0, b: 1'b1, d: 1'b0, r: 1'b0});
      end
      sb.push_back('{v: 1'b0, x: 1'b0, b: 1'b0, d: 1'b1, r: 1'b1});
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() != 0 && n < 600) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(posedge clk);
    #2;
    checkOutput("rst_ready", start_ready, 1);
    checkOutput("rst_x", x, 0);
    checkOutput("rst_xvalid", x_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single 1010 job");
    applyStimulus(16'h000A, 4'd3, 4'd0, 4'd0);
    waitDrain();

    $display("[TB] 1010 twice with gap of 2");
    applyStimulus(16'h000A, 4'd3, 4'd1, 4'd2);
    waitDrain();

    $display("[TB] 1-bit pattern x3, then back-to-back job from DONE");
    applyStimulus(16'h0001, 4'd0, 4'd2, 4'd0);
    applyStimulus(16'h0005, 4'd2, 4'd0, 4'd0);
    waitDrain();

    $display("[TB] full-length pattern with maximum gap");
    applyStimulus(16'($urandom), 4'd15, 4'd1, 4'd15);
    waitDrain();
    applyStimulus(16'($urandom), 4'd7, 4'd15, 4'd0);
    waitDrain();

    $display("[TB] abort during 2nd bit of a 16-bit job");
    applyStimulus(16'hBEEF, 4'd15, 4'd0, 4'd0);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    sb.delete();
    checkOutput("abort_ready", start_ready, 1);
    checkOutput("abort_xvalid", x_valid, 0);
    checkOutput("abort_busy", busy, 0);
    repeat (20) @(posedge clk);
    #1;

    $display("[TB] abort suppresses same-cycle handshake");
    start_valid = 1'b1;
    abort = 1'b1;
    pattern = 16'hFFFF;
    len_m1 = 4'd3;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    abort = 1'b0;
    checkOutput("abort_hs_busy", busy, 0);
    checkOutput("abort_hs_xvalid", x_valid, 0);
    repeat (4) @(posedge clk);
    #1;

    $display("[TB] reset mid-shift then fresh job");
    applyStimulus(16'h000A, 4'd3, 4'd3, 4'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("arst_xvalid", x_valid, 0);
    checkOutput("arst_x", x, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_done", done, 0);
    checkOutput("arst_ready", start_ready, 1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(16'h000A, 4'd3, 4'd0, 4'd0);
    waitDrain();

    $display("[TB] loopback 101010 into 1010 detector");
    applyStimulus(16'h002A, 4'd5, 4'd0, 4'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput($sformatf("loop_z_%0d", k), z, (k == 4) ? 1 : 0);
    end
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
